// File: rtl/pipe_flow_ctrl.sv
// Fetch/decode flow controller: boot/run/drain phase counter, PC register,
// IF/ID register and the decode/execute valid bits.
module pipe_flow_ctrl #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushE,
    input  logic            PCSrcD,
    input  logic [PC_W-1:0] PCBranchD,
    input  logic [31:0]     InstrF,
    input  logic            drain_req,
    output logic [3:0]      cnt,
    output logic [PC_W-1:0] PCF,
    output logic [PC_W-1:0] PCPlus4F,
    output logic [31:0]     InstrD,
    output logic [PC_W-1:0] PCPlus4D,
    output logic            validD,
    output logic            validE,
    output logic            drain_ack
);

    localparam logic [3:0] PH_RUN   = 4'd6;
    localparam logic [3:0] PH_HOLD  = 4'd7;
    localparam logic [3:0] PH_FLUSH = 4'd8;

    logic [3:0] cnt_nxt;
    logic       booting;
    logic       pc_frozen;

    assign booting   = (cnt < PH_RUN);
    assign pc_frozen = booting || (cnt == PH_HOLD);
    assign PCPlus4F  = PCF + PC_W'(4);

    // Phase sequencing; any out-of-range value recovers straight to run.
    always_comb begin
        cnt_nxt = PH_RUN;
        if (booting) begin
            cnt_nxt = cnt + 4'd1;
        end else if (cnt == PH_RUN) begin
            cnt_nxt = drain_req ? PH_HOLD : PH_RUN;
        end else if (cnt == PH_HOLD) begin
            cnt_nxt = PH_FLUSH;
        end
    end

    // drain_ack is decoded from the next phase so it leaves a flop, not a comparator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            drain_ack <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            drain_ack <= (cnt_nxt == PH_FLUSH);
        end
    end

    // Fetch stage: a stalled decode masks any redirect until it re-resolves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PCF <= RESET_PC;
        end else if (pc_frozen || StallF) begin
            PCF <= PCF;
        end else if (PCSrcD && !StallD) begin
            PCF <= PCBranchD;
        end else begin
            PCF <= PCPlus4F;
        end
    end

    // IF/ID boundary: a taken redirect turns the fetched slot into a nop bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            InstrD   <= 32'h0;
            PCPlus4D <= '0;
            validD   <= 1'b0;
        end else if (booting || StallD) begin
            InstrD   <= InstrD;
            PCPlus4D <= PCPlus4D;
            validD   <= validD;
        end else if (PCSrcD) begin
            InstrD   <= 32'h0;
            PCPlus4D <= '0;
            validD   <= 1'b0;
        end else begin
            InstrD   <= InstrF;
            PCPlus4D <= PCPlus4F;
            validD   <= 1'b1;
        end
    end

    // ID/EX boundary valid bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validE <= 1'b0;
        end else if (booting || FlushE) begin
            validE <= 1'b0;
        end else begin
            validE <= validD;
        end
    end

endmodule
